isa_camac_cycle_controller: RTL and testbench

//   Sequences one CAMAC backplane transfer per ISA I/O read/write cycle decoded in the board's window (0x100-0x13F).

---
 rtl/isa_camac_cycle_controller.sv | 186 ++++++++++++++++++
 tb/tb_isa_camac_cycle_controller.sv | 315 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/isa_camac_cycle_controller.sv
// ISA-to-CAMAC cycle controller. Each ISA I/O read or write that decodes into
// the board window becomes one CAMAC backplane transfer, with the ISA bus held
// in wait states until the strobe has finished.
//
// Handshake: a transfer is requested by a falling edge of the registered
// isa_ior/isa_iow while IDLE. isa_chrdy stays low from DECODE through the last
// STROBE cycle. The host may drop its command at any time. The transfer always
// finishes once started. If the command was dropped before HOLD, the transfer
// returns straight to IDLE. Otherwise it waits in HOLD until both commands are
// seen high.
module isa_camac_cycle_controller #(
  parameter logic [9:0] BASE_ADDR      = 10'h100,
  parameter int         SPAN_BITS      = 6,
  parameter int         STROBE_CYCLES  = 4,
  parameter int         TIMEOUT_CYCLES = 32
) (
  input  logic                 isa_clk,
  input  logic                 isa_reset,
  input  logic [9:0]           isa_addr,
  input  logic                 isa_ale,
  input  logic                 isa_aen,
  input  logic                 isa_ior,
  input  logic                 isa_iow,
  input  logic                 cb_prr,
  input  logic                 cb_cx1,
  input  logic                 err_clr,
  output logic                 isa_chrdy,
  output logic                 isa_data_oe,
  output logic [SPAN_BITS-1:0] cb_addr,
  output logic                 cb_rd,
  output logic                 cb_wr,
  output logic                 cb_strobe,
  output logic                 cb_data_oe,
  output logic                 data_latch,
  output logic                 x_resp,
  output logic                 err_timeout,
  output logic                 busy
);

  // One counter serves both the prr timeout and the strobe width.
  localparam int CNT_MAX = (TIMEOUT_CYCLES > STROBE_CYCLES) ? TIMEOUT_CYCLES : STROBE_CYCLES;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam logic [CW-1:0] STROBE_LAST  = CW'(STROBE_CYCLES - 1);
  localparam logic [CW-1:0] TIMEOUT_LAST = CW'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_DECODE   = 3'd1,
    S_WAIT_RDY = 3'd2,
    S_STROBE   = 3'd3,
    S_HOLD     = 3'd4
  } state_t;

  state_t        state;
  state_t        state_next;
  logic [9:0]    addr_q;
  logic          ior_q;
  logic          ior_qq;
  logic          iow_q;
  logic          iow_qq;
  logic          is_read;
  logic          released;
  logic [CW-1:0] cnt;
  logic          ior_fall;
  logic          iow_fall;
  logic          addr_hit;
  logic          cmd_idle;
  logic          start;
  logic          timeout_hit;

  assign ior_fall = !ior_q && ior_qq;
  assign iow_fall = !iow_q && iow_qq;
  assign addr_hit = (addr_q[9:SPAN_BITS] == BASE_ADDR[9:SPAN_BITS]);
  assign cmd_idle = ior_q && iow_q;
  // A start needs exactly one command asserted; a simultaneous ior+iow is ignored.
  assign start    = (state == S_IDLE) && !isa_aen && addr_hit &&
                    ((ior_fall && iow_q) || (iow_fall && ior_q));

  // Latch the ISA address on ALE and keep two samples of each command strobe.
  always_ff @(posedge isa_clk) begin
    if (isa_reset) begin
      addr_q <= '0;
      ior_q  <= 1'b1;
      ior_qq <= 1'b1;
      iow_q  <= 1'b1;
      iow_qq <= 1'b1;
    end else begin
      if (isa_ale) addr_q <= isa_addr;
      ior_q  <= isa_ior;
      ior_qq <= ior_q;
      iow_q  <= isa_iow;
      iow_qq <= iow_q;
    end
  end

  // State register plus the per-transfer context and sticky status.
  always_ff @(posedge isa_clk) begin
    if (isa_reset) begin
      state       <= S_IDLE;
      is_read     <= 1'b0;
      released    <= 1'b0;
      cnt         <= '0;
      cb_addr     <= '0;
      x_resp      <= 1'b0;
      err_timeout <= 1'b0;
    end else begin
      state <= state_next;
      if (start) begin
        is_read  <= !ior_q;
        released <= 1'b0;
        cb_addr  <= addr_q[SPAN_BITS-1:0];
      end else if ((state == S_DECODE || state == S_WAIT_RDY || state == S_STROBE) && cmd_idle) begin
        released <= 1'b1;
      end
      case (state)
        S_WAIT_RDY: cnt <= cb_prr ? '0 : cnt + 1'b1;
        S_STROBE:   cnt <= cnt + 1'b1;
        default:    cnt <= '0;
      endcase
      // X accumulates over the strobe; the first strobe cycle discards the old value.
      if (state == S_STROBE) begin
        x_resp <= (cnt == '0) ? !cb_cx1 : (x_resp || !cb_cx1);
      end
      // A timeout on the same edge as err_clr keeps the flag set.
      if (timeout_hit)  err_timeout <= 1'b1;
      else if (err_clr) err_timeout <= 1'b0;
    end
  end

  // Next-state decode and Moore outputs for the ISA and CAMAC sides.
  always_comb begin
    state_next  = state;
    timeout_hit = 1'b0;
    isa_chrdy   = 1'b1;
    isa_data_oe = 1'b0;
    cb_rd       = 1'b0;
    cb_wr       = 1'b0;
    cb_strobe   = 1'b0;
    cb_data_oe  = 1'b0;
    data_latch  = 1'b0;
    busy        = (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (start) state_next = S_DECODE;
      end
      S_DECODE: begin
        isa_chrdy  = 1'b0;
        cb_rd      = is_read;
        cb_wr      = !is_read;
        cb_data_oe = !is_read;
        state_next = S_WAIT_RDY;
      end
      S_WAIT_RDY: begin
        isa_chrdy  = 1'b0;
        cb_rd      = is_read;
        cb_wr      = !is_read;
        cb_data_oe = !is_read;
        if (cb_prr) begin
          state_next = S_STROBE;
        end else if (cnt == TIMEOUT_LAST) begin
          state_next  = S_HOLD;
          timeout_hit = 1'b1;
        end
      end
      S_STROBE: begin
        isa_chrdy  = 1'b0;
        cb_rd      = is_read;
        cb_wr      = !is_read;
        cb_data_oe = !is_read;
        cb_strobe  = 1'b1;
        data_latch = is_read && (cnt == STROBE_LAST);
        if (cnt == STROBE_LAST) begin
          state_next = (released || cmd_idle) ? S_IDLE : S_HOLD;
        end
      end
      S_HOLD: begin
        isa_data_oe = is_read;
        if (cmd_idle) state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_isa_camac_cycle_controller.sv
// Bench for isa_camac_cycle_controller: directed ISA cycles with hand-computed
// per-transfer summaries checked by a monitor that runs on the falling edge.
module tb_isa_camac_cycle_controller;

  localparam int RW = 36;

  logic       isa_clk;
  logic       isa_reset;
  logic [9:0] isa_addr;
  logic       isa_ale;
  logic       isa_aen;
  logic       isa_ior;
  logic       isa_iow;
  logic       cb_prr;
  logic       cb_cx1;
  logic       err_clr;
  logic       isa_chrdy;
  logic       isa_data_oe;
  logic [5:0] cb_addr;
  logic       cb_rd;
  logic       cb_wr;
  logic       cb_strobe;
  logic       cb_data_oe;
  logic       data_latch;
  logic       x_resp;
  logic       err_timeout;
  logic       busy;

  int total;
  int bad;
  int pushed;
  int records;

  logic [RW-1:0] exp_q[$];

  isa_camac_cycle_controller dut (
    .isa_clk     (isa_clk),
    .isa_reset   (isa_reset),
    .isa_addr    (isa_addr),
    .isa_ale     (isa_ale),
    .isa_aen     (isa_aen),
    .isa_ior     (isa_ior),
    .isa_iow     (isa_iow),
    .cb_prr      (cb_prr),
    .cb_cx1      (cb_cx1),
    .err_clr     (err_clr),
    .isa_chrdy   (isa_chrdy),
    .isa_data_oe (isa_data_oe),
    .cb_addr     (cb_addr),
    .cb_rd       (cb_rd),
    .cb_wr       (cb_wr),
    .cb_strobe   (cb_strobe),
    .cb_data_oe  (cb_data_oe),
    .data_latch  (data_latch),
    .x_resp      (x_resp),
    .err_timeout (err_timeout),
    .busy        (busy)
  );

  // ---------------- clock / reset ----------------
  initial isa_clk = 1'b0;
  always #5 isa_clk = ~isa_clk;

  // Transfer summary: chrdy-low cycles, strobe cycles, latch pulses,
  // cb_data_oe cycles, sub-address, rd/wr seen, isa_data_oe seen,
  // HOLD seen, final x_resp, final err_timeout.
  function automatic logic [RW-1:0] rec(input int chrdy_n, input int strobe_n,
                                        input int latch_n, input int doe_n,
                                        input logic [5:0] a, input logic rd,
                                        input logic wr, input logic oe,
                                        input logic hold, input logic x,
                                        input logic err);
    return {8'(chrdy_n), 4'(strobe_n), 4'(latch_n), 8'(doe_n), a, rd, wr, oe, hold, x, err};
  endfunction

  function automatic logic [15:0] out_vec();
    return {isa_chrdy, isa_data_oe, cb_addr, cb_rd, cb_wr, cb_strobe,
            cb_data_oe, data_latch, x_resp, err_timeout, busy};
  endfunction

  task automatic check(input string name, input logic [RW-1:0] got, input logic [RW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", name, got, exp);
    end
  endtask

  task automatic expire(input string name);
    total++;
    bad++;
    $display("FAIL %s: wait budget expired, got=timeout expected=event", name);
  endtask

  // ---------------- driver tasks ----------------
  task automatic start_cmd(input logic [9:0] a, input logic rd, input logic wr, input logic aen);
    @(posedge isa_clk); #1;
    isa_addr = a;
    isa_ale  = 1'b1;
    isa_aen  = aen;
    @(posedge isa_clk); #1;
    isa_ale  = 1'b0;
    isa_ior  = !rd;
    isa_iow  = !wr;
  endtask

  task automatic release_cmd();
    @(posedge isa_clk); #1;
    isa_ior = 1'b1;
    isa_iow = 1'b1;
    isa_aen = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge isa_clk);
      if (busy === lvl) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) expire(name);
  endtask

  task automatic wait_hold(input int budget, input string name);
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge isa_clk);
      if (busy === 1'b1 && isa_chrdy === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    if (!ok) expire(name);
  endtask

  // Full transfer that ends in HOLD and is released by the host.
  task automatic run_xfer(input logic [9:0] a, input logic rd, input logic wr, input string name);
    start_cmd(a, rd, wr, 1'b0);
    wait_busy(1'b1, 10, name);
    wait_hold(60, name);
    repeat (2) @(posedge isa_clk);
    release_cmd();
    wait_busy(1'b0, 10, name);
  endtask

  // A cycle that must not start a transfer.
  task automatic quiet(input logic [9:0] a, input logic rd, input logic wr, input logic aen,
                       input string name);
    int viol;
    viol = 0;
    start_cmd(a, rd, wr, aen);
    repeat (10) begin
      @(negedge isa_clk);
      if (busy !== 1'b0 || isa_chrdy !== 1'b1 || cb_rd !== 1'b0 || cb_wr !== 1'b0 ||
          cb_strobe !== 1'b0 || cb_data_oe !== 1'b0 || data_latch !== 1'b0 ||
          isa_data_oe !== 1'b0) viol++;
    end
    check(name, RW'(viol), RW'(0));
    release_cmd();
    repeat (3) @(posedge isa_clk);
  endtask

  // ---------------- scoreboard monitor ----------------
  logic busy_d = 1'b0;
  logic mon_abort = 1'b0;
  int   m_chrdy, m_strobe, m_latch, m_doe;
  logic [5:0] m_addr;
  logic m_rd, m_wr, m_oe, m_hold;

  always @(negedge isa_clk) begin
    logic [RW-1:0] got;
    logic [RW-1:0] exp;
    if (isa_reset === 1'b1) mon_abort = 1'b1;
    if (busy === 1'b1 && busy_d === 1'b0) begin
      mon_abort = 1'b0;
      m_chrdy = 0; m_strobe = 0; m_latch = 0; m_doe = 0;
      m_addr = '0; m_rd = 0; m_wr = 0; m_oe = 0; m_hold = 0;
    end
    if (busy === 1'b1) begin
      if (isa_chrdy === 1'b0) m_chrdy++;
      if (cb_strobe === 1'b1) m_strobe++;
      if (data_latch === 1'b1) m_latch++;
      if (cb_data_oe === 1'b1) m_doe++;
      if (cb_rd === 1'b1 || cb_wr === 1'b1) m_addr = cb_addr;
      m_rd   = m_rd | (cb_rd === 1'b1);
      m_wr   = m_wr | (cb_wr === 1'b1);
      m_oe   = m_oe | (isa_data_oe === 1'b1);
      m_hold = m_hold | (isa_chrdy === 1'b1);
    end
    if (busy === 1'b0 && busy_d === 1'b1) begin
      if (mon_abort) begin
        mon_abort = 1'b0;
      end else begin
        records++;
        got = rec(m_chrdy, m_strobe, m_latch, m_doe, m_addr, m_rd, m_wr, m_oe, m_hold,
                  x_resp, err_timeout);
        if (exp_q.size() == 0) begin
          check("unexpected_transfer", got, '0);
        end else begin
          exp = exp_q.pop_front();
          check($sformatf("transfer_%0d", records), got, exp);
        end
      end
    end
    busy_d = busy;
  end

  // ---------------- stimulus ----------------
  initial begin
    total = 0; bad = 0; pushed = 0; records = 0;
    isa_reset = 1'b1; isa_addr = '0; isa_ale = 1'b0; isa_aen = 1'b0;
    isa_ior = 1'b1; isa_iow = 1'b1; cb_prr = 1'b1; cb_cx1 = 1'b1; err_clr = 1'b0;
    repeat (3) @(posedge isa_clk);
    #1 isa_reset = 1'b0;
    @(negedge isa_clk);
    check("reset_outputs", RW'(out_vec()), RW'(16'h8000));

    // Read at window base, X asserted on every strobe cycle.
    cb_cx1 = 1'b0;
    exp_q.push_back(rec(6, 4, 1, 0, 6'h00, 1, 0, 1, 1, 1, 0)); pushed++;
    run_xfer(10'h100, 1'b1, 1'b0, "read_100");
    cb_cx1 = 1'b1;

    // Write at top of window, no X.
    exp_q.push_back(rec(6, 4, 0, 6, 6'h3F, 0, 1, 0, 1, 0, 0)); pushed++;
    run_xfer(10'h13F, 1'b0, 1'b1, "write_13f");

    // Write with X low only on the second strobe cycle.
    exp_q.push_back(rec(6, 4, 0, 6, 6'h2A, 0, 1, 0, 1, 1, 0)); pushed++;
    start_cmd(10'h12A, 1'b0, 1'b1, 1'b0);
    wait_busy(1'b1, 10, "write_12a");
    repeat (2) begin @(posedge isa_clk); #1; end
    @(posedge isa_clk); #1 cb_cx1 = 1'b0;
    @(posedge isa_clk); #1 cb_cx1 = 1'b1;
    wait_hold(20, "write_12a");
    repeat (2) @(posedge isa_clk);
    release_cmd();
    wait_busy(1'b0, 10, "write_12a");

    // Out-of-window, DMA and double-command cycles.
    quiet(10'h140, 1'b1, 1'b0, 1'b0, "quiet_140");
    quiet(10'h0FF, 1'b1, 1'b0, 1'b0, "quiet_0ff");
    quiet(10'h120, 1'b1, 1'b0, 1'b1, "quiet_aen_120");
    quiet(10'h110, 1'b1, 1'b1, 1'b0, "quiet_both_110");

    // Timeout with err_clr held high across the abort edge: the set wins.
    exp_q.push_back(rec(33, 0, 0, 0, 6'h05, 1, 0, 1, 1, 1, 1)); pushed++;
    err_clr = 1'b1;
    cb_prr  = 1'b0;
    start_cmd(10'h105, 1'b1, 1'b0, 1'b0);
    wait_busy(1'b1, 10, "timeout_105");
    wait_hold(60, "timeout_105");
    err_clr = 1'b0;
    cb_prr  = 1'b1;
    repeat (2) @(posedge isa_clk);
    release_cmd();
    wait_busy(1'b0, 10, "timeout_105");
    @(negedge isa_clk);
    check("err_sticky", RW'(err_timeout), RW'(1));
    @(posedge isa_clk); #1 err_clr = 1'b1;
    @(posedge isa_clk); #1 err_clr = 1'b0;
    @(negedge isa_clk);
    check("err_cleared", RW'(err_timeout), RW'(0));

    // Reset pulsed on the second strobe cycle.
    cb_cx1 = 1'b0;
    start_cmd(10'h10C, 1'b1, 1'b0, 1'b0);
    wait_busy(1'b1, 10, "reset_mid");
    repeat (3) begin @(posedge isa_clk); #1; end
    check("pre_reset_strobe_x", RW'({cb_strobe, x_resp}), RW'(2'b11));
    isa_reset = 1'b1;
    isa_ior   = 1'b1;
    cb_cx1    = 1'b1;
    @(posedge isa_clk); #1 isa_reset = 1'b0;
    @(negedge isa_clk);
    check("post_reset_outputs", RW'(out_vec()), RW'(16'h8000));

    exp_q.push_back(rec(6, 4, 1, 0, 6'h01, 1, 0, 1, 1, 0, 0)); pushed++;
    run_xfer(10'h101, 1'b1, 1'b0, "read_101");

    // ior released during WAIT_RDY: strobe completes, no HOLD.
    exp_q.push_back(rec(9, 4, 1, 0, 6'h20, 1, 0, 0, 0, 1, 0)); pushed++;
    cb_cx1 = 1'b0;
    cb_prr = 1'b0;
    start_cmd(10'h120, 1'b1, 1'b0, 1'b0);
    wait_busy(1'b1, 10, "release_120");
    @(posedge isa_clk); #1;
    @(posedge isa_clk); #1;
    @(posedge isa_clk); #1 isa_ior = 1'b1;
    @(posedge isa_clk); #1 cb_prr = 1'b1;
    wait_busy(1'b0, 20, "release_120");
    cb_cx1 = 1'b1;

    repeat (5) @(posedge isa_clk);
    check("records_seen", RW'(records), RW'(pushed));
    check("queue_empty", RW'(exp_q.size()), RW'(0));

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    bad++;
    $display("FAIL watchdog: got=running expected=finished");
    $display("test done: total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
